pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline control for the 5-stage core. Consumes the jump request leaving
//  the mem_wb pipeline register and the per-stage stall requests. Produces
//  the 3-bit hold_flag that every gen_pipe_dff stage register compares
//  against its level; a held stage loads its default value, i.e. a bubble.
//  Also drives the PC redirect. Owns the flush FSM, the stall watchdog and
//  the jump performance counter.
// PARAMETERS
//  FLUSH_EXTRA    1   extra Hold_Id cycles after the jump cycle (1..15)
//  STALL_TIMEOUT  16  consecutive stall cycles that set stall_timeout_o (>=2)
//  CNT_W          16  width of jump_count_o
// PORTS
//  clk              in   1      clock; all state changes on posedge
//  rst              in   1      synchronous reset, active-high
//  jump_flag_i      in   1      jump/branch taken, from mem_wb
//  jump_addr_i      in   32     jump target, from mem_wb
//  stall_req_id_i   in   1      load-use hazard from id
//  stall_req_ex_i   in   1      multi-cycle ex op busy
//  stall_req_bus_i  in   1      instruction fetch bus not ready
//  hold_flag_o      out  3      000 none, 001 Hold_Pc, 010 Hold_If, 011 Hold_Id
//  redirect_o       out  1      load redirect_addr_o into PC this cycle
//  redirect_addr_o  out  32     new PC
//  flushing_o       out  1      FSM in S_FLUSH
//  stall_timeout_o  out  1      sticky watchdog error
//  jump_count_o     out  CNT_W  accepted jumps, saturating
// BEHAVIOUR
//  - rst=1: every output is 0, including the combinational ones.
//    State=S_RUN; flush_cnt, stall_cnt and jump_count are all 0.
//  - Jump acceptance: jump_flag_i && state==S_RUN && !rst. Accepted in cycle N:
//    . Cycle N (combinational): redirect_o=1, redirect_addr_o=jump_addr_i,
//      hold_flag_o=Hold_Id.
//    . Posedge ending N: state<=S_FLUSH, flush_cnt<=FLUSH_EXTRA,
//      jump_count+1, saturating at all-ones.
//  - S_FLUSH: hold_flag_o=Hold_Id, flushing_o=1, redirect_o=0.
//    flush_cnt decrements each cycle; on the cycle where flush_cnt==1,
//    next state is S_RUN. Total Hold_Id cycles per jump = 1+FLUSH_EXTRA.
//  - jump_flag_i while in S_FLUSH is ignored: it belongs to a squashed
//    instruction. No redirect, no count.
//  - Stall hold level: ex -> Hold_Id, id -> Hold_If, bus -> Hold_Pc.
//    hold_flag_o = max of the active stall levels and the jump/flush level.
//    This is combinational, so it applies in the same cycle as the request.
//  - redirect_addr_o=0 whenever redirect_o=0.
//  - Watchdog: stall_cnt increments in every cycle with any stall_req_*=1,
//    saturating at STALL_TIMEOUT, and clears to 0 in any cycle with none.
//    stall_timeout_o is registered and sets on the posedge where stall_cnt
//    reaches STALL_TIMEOUT. It stays set until rst.
//  - Reset in the middle of a flush: S_RUN on the next edge. No residual hold.
//  - FSM states: S_RUN, S_FLUSH only. An unused state encoding goes to S_RUN.
// TESTING
//  T1 rst=1 for 3 cycles with all inputs toggling -> all outputs 0.
//     First cycle after rst: hold_flag_o=000.
//  T2 FLUSH_EXTRA=1; jump_flag_i=1, jump_addr_i=32'h0000_0100 in cycle 5 ->
//     cycle 5: redirect_o=1, redirect_addr_o=32'h100, hold_flag_o=011.
//     Cycle 6: hold_flag_o=011, flushing_o=1. Cycle 7: 000. jump_count_o=1.
//  T3 Jump in cycle 5, then jump_flag_i=1 again in cycle 6 ->
//     no redirect in cycle 6; jump_count_o stays 1.
//  T4 stall_req_id_i=1 and stall_req_bus_i=1 in the same cycle ->
//     hold_flag_o=010. Add stall_req_ex_i=1 -> 011. Drop all three -> 000
//     in the same cycle.
//  T5 STALL_TIMEOUT=16; stall_req_ex_i=1 for 15 cycles -> stall_timeout_o=0.
//     Stalls for 16 consecutive cycles -> stall_timeout_o=1, still 1 after
//     the stalls drop. Pulse rst -> 0.
//  T6 Jump in cycle 5 with FLUSH_EXTRA=3; rst=1 in cycle 7 ->
//     cycle 8: hold_flag_o=000, flushing_o=0, jump_count_o=0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: hold_flag generation, PC redirect on
// taken jumps, post-jump flush sequencing, stall watchdog and jump counter.
module pipe_ctrl #(
  parameter int unsigned FLUSH_EXTRA   = 1,
  parameter int unsigned STALL_TIMEOUT = 16,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             stall_req_id_i,
  input  logic             stall_req_ex_i,
  input  logic             stall_req_bus_i,
  output logic [2:0]       hold_flag_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_addr_o,
  output logic             flushing_o,
  output logic             stall_timeout_o,
  output logic [CNT_W-1:0] jump_count_o
);

  localparam int unsigned FC_W = 4;
  localparam int unsigned SC_W = $clog2(STALL_TIMEOUT + 1);

  localparam logic [2:0] HOLD_NONE = 3'b000;
  localparam logic [2:0] HOLD_PC   = 3'b001;
  localparam logic [2:0] HOLD_IF   = 3'b010;
  localparam logic [2:0] HOLD_ID   = 3'b011;

  typedef enum logic [1:0] {
    S_RUN   = 2'b00,
    S_FLUSH = 2'b01
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [FC_W-1:0]   flush_cnt;
  logic [SC_W-1:0]   stall_cnt;
  logic [SC_W-1:0]   stall_cnt_nxt;
  logic [CNT_W-1:0]  jump_count;
  logic              stall_timeout;
  logic              jump_acc;
  logic              any_stall;

  // A jump is only honoured from S_RUN; during a flush it belongs to a squashed instruction.
  assign jump_acc  = jump_flag_i && (state == S_RUN) && !rst;
  assign any_stall = stall_req_id_i || stall_req_ex_i || stall_req_bus_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (jump_acc) begin
          state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (flush_cnt <= FC_W'(1)) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // Outputs: highest of stall level and jump/flush level; everything forced low in reset
  always_comb begin
    hold_flag_o     = HOLD_NONE;
    redirect_o      = 1'b0;
    redirect_addr_o = 32'h0;
    flushing_o      = 1'b0;
    stall_timeout_o = 1'b0;
    jump_count_o    = '0;
    if (!rst) begin
      if (stall_req_ex_i) begin
        hold_flag_o = HOLD_ID;
      end else if (stall_req_id_i) begin
        hold_flag_o = HOLD_IF;
      end else if (stall_req_bus_i) begin
        hold_flag_o = HOLD_PC;
      end
      case (state)
        S_RUN: begin
          if (jump_flag_i) begin
            redirect_o      = 1'b1;
            redirect_addr_o = jump_addr_i;
            hold_flag_o     = HOLD_ID;
          end
        end
        S_FLUSH: begin
          hold_flag_o = HOLD_ID;
          flushing_o  = 1'b1;
        end
        default: ;
      endcase
      stall_timeout_o = stall_timeout;
      jump_count_o    = jump_count;
    end
  end

  // Watchdog count saturates so the sticky flag cannot be missed by wraparound
  always_comb begin
    stall_cnt_nxt = '0;
    if (any_stall) begin
      if (stall_cnt == SC_W'(STALL_TIMEOUT)) begin
        stall_cnt_nxt = stall_cnt;
      end else begin
        stall_cnt_nxt = stall_cnt + SC_W'(1);
      end
    end
  end

  // Flush counter, stall watchdog and jump counter
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt     <= '0;
      stall_cnt     <= '0;
      jump_count    <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (jump_acc) begin
        flush_cnt <= FC_W'(FLUSH_EXTRA);
        if (jump_count != '1) begin
          jump_count <= jump_count + CNT_W'(1);
        end
      end else if ((state == S_FLUSH) && (flush_cnt != '0)) begin
        flush_cnt <= flush_cnt - FC_W'(1);
      end
      stall_cnt <= stall_cnt_nxt;
      if (stall_cnt_nxt == SC_W'(STALL_TIMEOUT)) begin
        stall_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (short flush / long flush with narrow
// counter) driven in lockstep and compared against a cycle-level reference model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jf;
  logic [31:0] ja;
  logic        sid, sex, sbus;

  logic [2:0]  h1, h3;
  logic        r1, r3, f1, f3, t1, t3;
  logic [31:0] a1, a3;
  logic [15:0] c1;
  logic [2:0]  c3;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state, index 0 -> u_dut1, index 1 -> u_dut3
  int fl_left [2];
  int jumps   [2];
  int stall_run;
  bit timeout;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_EXTRA(1), .STALL_TIMEOUT(16), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .jump_flag_i(jf), .jump_addr_i(ja),
    .stall_req_id_i(sid), .stall_req_ex_i(sex), .stall_req_bus_i(sbus),
    .hold_flag_o(h1), .redirect_o(r1), .redirect_addr_o(a1), .flushing_o(f1),
    .stall_timeout_o(t1), .jump_count_o(c1)
  );

  pipe_ctrl #(.FLUSH_EXTRA(3), .STALL_TIMEOUT(16), .CNT_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .jump_flag_i(jf), .jump_addr_i(ja),
    .stall_req_id_i(sid), .stall_req_ex_i(sex), .stall_req_bus_i(sbus),
    .hold_flag_o(h3), .redirect_o(r3), .redirect_addr_o(a3), .flushing_o(f3),
    .stall_timeout_o(t3), .jump_count_o(c3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int flush_extra(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int count_max(input int i);
    return (i == 0) ? 65535 : 7;
  endfunction

  // One clock cycle: drive inputs, check all outputs mid-cycle, advance the model.
  task automatic step(input bit r, input bit j, input logic [31:0] addr,
                      input bit s_id, input bit s_ex, input bit s_bus);
    int stall_lvl;
    rst = r; jf = j; ja = addr; sid = s_id; sex = s_ex; sbus = s_bus;
    @(negedge clk);
    stall_lvl = s_ex ? 3 : (s_id ? 2 : (s_bus ? 1 : 0));
    for (int i = 0; i < 2; i++) begin
      bit accept;
      int e_hold;
      logic [2:0]  o_h;
      logic        o_r, o_f, o_t;
      logic [31:0] o_a;
      logic [15:0] o_c;
      accept = !r && j && (fl_left[i] == 0);
      e_hold = (accept || fl_left[i] > 0) ? 3 : 0;
      if (stall_lvl > e_hold) e_hold = stall_lvl;
      if (r) e_hold = 0;
      if (i == 0) begin o_h = h1; o_r = r1; o_a = a1; o_f = f1; o_t = t1; o_c = c1; end
      else        begin o_h = h3; o_r = r3; o_a = a3; o_f = f3; o_t = t3; o_c = 16'(c3); end
      check($sformatf("hold%0d", i), 64'(o_h), 64'(e_hold));
      check($sformatf("redirect%0d", i), 64'(o_r), 64'(accept));
      check($sformatf("raddr%0d", i), 64'(o_a), accept ? 64'(addr) : 64'h0);
      check($sformatf("flushing%0d", i), 64'(o_f), 64'(!r && fl_left[i] > 0));
      check($sformatf("timeout%0d", i), 64'(o_t), 64'(!r && timeout));
      check($sformatf("jcount%0d", i), 64'(o_c), r ? 64'h0 : 64'(jumps[i]));
      // state update at the coming posedge
      if (r) begin
        fl_left[i] = 0;
        jumps[i]   = 0;
      end else if (accept) begin
        fl_left[i] = flush_extra(i);
        if (jumps[i] < count_max(i)) jumps[i]++;
      end else if (fl_left[i] > 0) begin
        fl_left[i]--;
      end
    end
    if (r) begin
      stall_run = 0;
      timeout   = 1'b0;
    end else begin
      stall_run = (s_id || s_ex || s_bus) ? stall_run + 1 : 0;
      if (stall_run >= 16) timeout = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 32'h0, 0, 0, 0);
  endtask

  initial begin
    int mode;
    fl_left = '{0, 0};
    jumps   = '{0, 0};
    stall_run = 0;
    timeout   = 1'b0;
    rst = 1'b1; jf = 1'b0; ja = '0; sid = 1'b0; sex = 1'b0; sbus = 1'b0;

    // T1: reset with toggling inputs
    for (int k = 0; k < 3; k++) step(1, 1, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    step(0, 0, 32'h0, 0, 0, 0);
    check("t1_hold_after_rst", 64'(h1), 64'h0);

    // T2: single jump with one extra flush cycle
    idle(3);
    step(0, 1, 32'h0000_0100, 0, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0);
    check("t2_flush_done", 64'(f1), 64'h0);
    step(0, 0, 32'h0, 0, 0, 0);
    check("t2_jcount", 64'(c1), 64'h1);

    // T3: jump during flush is ignored
    step(0, 1, 32'h0000_0200, 0, 0, 0);
    step(0, 1, 32'h0000_0300, 0, 0, 0);
    check("t3_jcount", 64'(c1), 64'h2);
    idle(4);

    // T4: stall level priority
    step(0, 0, 32'h0, 1, 0, 1);
    step(0, 0, 32'h0, 1, 1, 1);
    step(0, 0, 32'h0, 0, 0, 0);

    // T5: watchdog threshold and stickiness
    for (int k = 0; k < 15; k++) step(0, 0, 32'h0, 0, 1, 0);
    check("t5_no_timeout_15", 64'(t1), 64'h0);
    step(0, 0, 32'h0, 0, 1, 0);
    check("t5_timeout_16", 64'(t1), 64'h1);
    idle(2);
    check("t5_sticky", 64'(t1), 64'h1);
    step(1, 0, 32'h0, 0, 0, 0);
    idle(1);
    check("t5_cleared", 64'(t1), 64'h0);

    // T6: reset in the middle of a long flush
    idle(2);
    step(0, 1, 32'h0000_0400, 0, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0);
    step(1, 0, 32'h0, 0, 0, 0);
    step(0, 0, 32'h0, 0, 0, 0);
    check("t6_count_after_rst", 64'(c3), 64'h0);
    check("t6_flush_after_rst", 64'(f3), 64'h0);

    // Random phase: mix of jump-heavy, stall-burst and quiet stretches
    mode = 0;
    for (int k = 0; k < 3000; k++) begin
      bit r_r, r_j, r_id, r_ex, r_bus;
      if ($urandom_range(0, 63) == 0) mode = $urandom_range(0, 2);
      r_r = ($urandom_range(0, 299) == 0);
      case (mode)
        0: begin
          r_j = ($urandom_range(0, 2) == 0);
          r_id = ($urandom_range(0, 7) == 0); r_ex = ($urandom_range(0, 7) == 0);
          r_bus = ($urandom_range(0, 7) == 0);
        end
        1: begin
          r_j = ($urandom_range(0, 9) == 0);
          r_id = ($urandom_range(0, 1) == 0); r_ex = ($urandom_range(0, 1) == 0);
          r_bus = ($urandom_range(0, 1) == 0) || ($urandom_range(0, 3) != 0);
        end
        default: begin
          r_j = ($urandom_range(0, 15) == 0);
          r_id = 1'b0; r_ex = 1'b0; r_bus = ($urandom_range(0, 15) == 0);
        end
      endcase
      step(r_r, r_j, $urandom, r_id, r_ex, r_bus);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
